// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the elastic pipeline stage register.
package pipe_pkg;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 128;
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 101;
  localparam int EXMEM_CTRL_W = 10;
  localparam int MEMWB_DATA_W = 96;
  localparam int MEMWB_CTRL_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } slot_state_e;

  // Width needed to count up to two entries per stage.
  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic pipeline stage: either a 2-entry skid slot with registered in_ready,
// or a single register whose ready is passed through combinationally.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = 104,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bundle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bundle
);

  generate
    if (SKID) begin : g_skid
      slot_state_e      r_state;
      slot_state_e      w_state_nxt;
      logic             r_in_ready;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             w_push;
      logic             w_pop;

      assign w_push     = in_valid && r_in_ready;
      assign w_pop      = (r_state != EMPTY) && out_ready;
      assign in_ready   = r_in_ready;
      assign out_valid  = (r_state != EMPTY);
      assign out_bundle = r_main;

      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          EMPTY: begin
            if (w_push) w_state_nxt = MAIN;
            else        w_state_nxt = EMPTY;
          end
          MAIN: begin
            if (w_push && !w_pop)      w_state_nxt = FULL;
            else if (!w_push && w_pop) w_state_nxt = EMPTY;
            else                       w_state_nxt = MAIN;
          end
          FULL: begin
            if (w_pop) w_state_nxt = MAIN;
            else       w_state_nxt = FULL;
          end
          default: w_state_nxt = EMPTY;
        endcase
        if (flush) w_state_nxt = EMPTY;
        else       w_state_nxt = w_state_nxt;
      end

      // Flush only drops occupancy; payload registers are left untouched.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
          r_main     <= {WIDTH{1'b0}};
          r_skid     <= {WIDTH{1'b0}};
        end else begin
          r_state    <= w_state_nxt;
          r_in_ready <= (w_state_nxt != FULL);
          if (!flush) begin
            if (r_state == FULL && w_pop)
              r_main <= r_skid;
            else if (w_push && (r_state == EMPTY || w_pop))
              r_main <= in_bundle;
            if (w_push && r_state == MAIN && !w_pop)
              r_skid <= in_bundle;
          end
        end
      end
    end else begin : g_pass
      logic             r_valid;
      logic [WIDTH-1:0] r_data;
      logic             w_push;
      logic             w_pop;

      assign in_ready   = out_ready || !r_valid;
      assign w_push     = in_valid && in_ready;
      assign w_pop      = r_valid && out_ready;
      assign out_valid  = r_valid;
      assign out_bundle = r_data;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_data  <= {WIDTH{1'b0}};
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_push) begin
          r_valid <= 1'b1;
          r_data  <= in_bundle;
        end else if (w_pop) begin
          r_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: DEPTH chained slots carrying {ctrl, data} with
// valid/ready handshake, flush, occupancy count and bubble masking of ctrl.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 8,
  parameter int DEPTH      = 1,
  parameter bit SKID       = 1'b1,
  parameter bit CTRL_CLEAR = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [CTRL_W-1:0]       out_ctrl,
  input  logic                    flush,
  output logic [occ_w(DEPTH)-1:0] occupancy
);

  localparam int WIDTH = DATA_W + CTRL_W;
  localparam int OCC_W = occ_w(DEPTH);

  logic              w_valid  [DEPTH+1];
  logic [WIDTH-1:0]  w_bundle [DEPTH+1];
  logic              w_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [CTRL_W-1:0] w_ctrl_raw;
  logic [OCC_W-1:0]  r_occ;

  assign w_valid[0]  = in_valid;
  assign w_bundle[0] = {in_ctrl, in_data};

  // Ready flows backwards, so each stage looks one generate block downstream.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic w_in_ready;
      logic w_out_ready;
      if (k == DEPTH - 1) begin : g_tail
        assign w_out_ready = out_ready;
      end else begin : g_link
        assign w_out_ready = g_stage[k+1].w_in_ready;
      end
      pipe_skid_slot #(
        .WIDTH (WIDTH),
        .SKID  (SKID)
      ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (w_valid[k]),
        .in_ready   (w_in_ready),
        .in_bundle  (w_bundle[k]),
        .out_valid  (w_valid[k+1]),
        .out_ready  (w_out_ready),
        .out_bundle (w_bundle[k+1])
      );
    end
  endgenerate

  assign in_ready    = g_stage[0].w_in_ready;
  assign w_out_valid = w_valid[DEPTH] && !reset;
  assign w_in_xfer   = in_valid && in_ready;
  assign w_out_xfer  = w_out_valid && out_ready;
  assign w_ctrl_raw  = w_bundle[DEPTH][WIDTH-1:DATA_W];

  assign out_valid = w_out_valid;
  assign out_data  = w_bundle[DEPTH][DATA_W-1:0];
  assign out_ctrl  = (CTRL_CLEAR && !w_out_valid) ? {CTRL_W{1'b0}} : w_ctrl_raw;
  assign occupancy = r_occ;

  // Total held entries change only through the outer handshakes.
  always_ff @(posedge clk) begin
    if (reset || flush)
      r_occ <= {OCC_W{1'b0}};
    else if (w_in_xfer && !w_out_xfer)
      r_occ <= r_occ + OCC_W'(1);
    else if (!w_in_xfer && w_out_xfer)
      r_occ <= r_occ - OCC_W'(1);
    else
      r_occ <= r_occ;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: four configurations of pipe_stage_reg against a FIFO model
// plus directed literal scenarios.
module tb_pipe_stage_reg;

  localparam int N = 4;
  localparam int DEP [N] = '{1, 2, 3, 2};
  localparam bit SKD [N] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam bit CCL [N] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        iv [N], ir [N], ov [N], ordy [N], fl [N], rs [N];
  logic [15:0] id [N], od [N];
  logic [7:0]  ic [N], oc [N];
  logic [1:0]  occ0;
  logic [2:0]  occ1, occ2, occ3;

  int checks = 0;
  int failures = 0;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .DEPTH(1), .SKID(1'b1), .CTRL_CLEAR(1'b1)) u_d0 (
    .clk(clk), .reset(rs[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_ctrl(ic[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ctrl(oc[0]), .flush(fl[0]), .occupancy(occ0));
  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .DEPTH(2), .SKID(1'b1), .CTRL_CLEAR(1'b0)) u_d1 (
    .clk(clk), .reset(rs[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_ctrl(ic[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ctrl(oc[1]), .flush(fl[1]), .occupancy(occ1));
  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .DEPTH(3), .SKID(1'b1), .CTRL_CLEAR(1'b1)) u_d2 (
    .clk(clk), .reset(rs[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]), .in_ctrl(ic[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_ctrl(oc[2]), .flush(fl[2]), .occupancy(occ2));
  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .DEPTH(2), .SKID(1'b0), .CTRL_CLEAR(1'b1)) u_d3 (
    .clk(clk), .reset(rs[3]), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]), .in_ctrl(ic[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .out_ctrl(oc[3]), .flush(fl[3]), .occupancy(occ3));

  function automatic logic [3:0] get_occ(input int i);
    case (i)
      0:       return {2'b00, occ0};
      1:       return {1'b0, occ1};
      2:       return {1'b0, occ2};
      default: return {1'b0, occ3};
    endcase
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst=%0d actual=0x%0h required=0x%0h", name, inst, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each instance is an ordered FIFO of accepted bundles; the output must
  // always present the oldest one, and must present it within DEPTH-1 idle cycles.
  logic [23:0] mq [N][8];
  int          mh [N], mc [N], stall_cnt [N];
  logic [15:0] last_d [N];
  logic [7:0]  last_c [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      mh[i] = 0; mc[i] = 0; stall_cnt[i] = 0; last_d[i] = 16'h0; last_c[i] = 8'h0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rs[i] === 1'b1) begin
          mh[i] = 0; mc[i] = 0; stall_cnt[i] = 0; last_d[i] = 16'h0; last_c[i] = 8'h0;
        end else begin
          check("occupancy", i, get_occ(i), mc[i]);
          if (mc[i] == 0) begin
            check("valid_when_empty", i, ov[i], 1'b0);
            check("ready_when_empty", i, ir[i], 1'b1);
          end
          if (ov[i] === 1'b1) begin
            check("head_bundle", i, {oc[i], od[i]}, mq[i][mh[i]]);
          end else begin
            check("bubble_data", i, od[i], last_d[i]);
            check("bubble_ctrl", i, oc[i], CCL[i] ? 8'h00 : last_c[i]);
          end
          if (!SKD[i])
            check("comb_ready", i, ir[i], ordy[i] || (mc[i] < DEP[i]));
          else if (mc[i] == 2 * DEP[i])
            check("ready_when_full", i, ir[i], 1'b0);
          if (mc[i] > 0 && ov[i] !== 1'b1) begin
            stall_cnt[i]++;
            check("fill_latency", i, stall_cnt[i] > DEP[i] - 1, 1'b0);
          end else begin
            stall_cnt[i] = 0;
          end
          if (ov[i] === 1'b1) begin
            last_d[i] = od[i];
            last_c[i] = oc[i];
          end
          if (fl[i]) begin
            mh[i] = 0; mc[i] = 0; stall_cnt[i] = 0;
          end else begin
            if (ov[i] && ordy[i]) begin
              mh[i] = (mh[i] + 1) % 8;
              mc[i]--;
            end
            if (iv[i] && ir[i]) begin
              mq[i][(mh[i] + mc[i]) % 8] = {ic[i], id[i]};
              mc[i]++;
            end
          end
        end
      end
    end
  end

  initial begin
    int acc;
    logic go;
    for (int i = 0; i < N; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; fl[i] = 1'b0; rs[i] = 1'b1; id[i] = 16'h0; ic[i] = 8'h0;
    end
    tick(); tick();
    for (int i = 0; i < N; i++) rs[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("rst_valid", i, ov[i], 1'b0);
      check("rst_data", i, od[i], 16'h0);
      check("rst_occ", i, get_occ(i), 4'd0);
      check("rst_ready", i, ir[i], 1'b1);
      check("rst_ctrl", i, oc[i], 8'h00);
    end

    // DEPTH=1 streaming, then bubble clears ctrl
    ordy[0] = 1'b1; ic[0] = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      id[0] = 16'(16'h0011 + k); iv[0] = 1'b1;
      tick();
      check("stream_valid", 0, ov[0], 1'b1);
      check("stream_data", 0, od[0], 16'(16'h0011 + k));
      check("stream_ctrl", 0, oc[0], 8'hA5);
      check("stream_occ", 0, get_occ(0), 4'd1);
      check("stream_ready", 0, ir[0], 1'b1);
    end
    iv[0] = 1'b0;
    tick();
    check("idle_valid", 0, ov[0], 1'b0);
    check("idle_ctrl_cleared", 0, oc[0], 8'h00);
    check("idle_data_kept", 0, od[0], 16'h0015);
    check("idle_occ", 0, get_occ(0), 4'd0);

    // DEPTH=2 backpressure fills four entries, then drains in order
    ordy[1] = 1'b0; ic[1] = 8'hA5; acc = 0;
    for (int k = 0; k < 6; k++) begin
      id[1] = 16'(16'h0021 + acc); iv[1] = 1'b1; go = ir[1];
      tick();
      if (go) acc++;
    end
    iv[1] = 1'b0;
    check("stall_accepts", 1, acc, 4);
    check("stall_occ", 1, get_occ(1), 4'd4);
    check("stall_ready", 1, ir[1], 1'b0);
    ordy[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 1, ov[1], 1'b1);
      check("drain_data", 1, od[1], 16'(16'h0021 + k));
      tick();
    end
    check("drained_valid", 1, ov[1], 1'b0);
    check("drained_occ", 1, get_occ(1), 4'd0);
    check("hold_ctrl", 1, oc[1], 8'hA5);

    // DEPTH=3 flush with a colliding push
    ordy[2] = 1'b0; ic[2] = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      id[2] = 16'(16'h0031 + k); iv[2] = 1'b1;
      tick();
    end
    check("inflight_occ", 2, get_occ(2), 4'd3);
    check("inflight_head", 2, od[2], 16'h0031);
    fl[2] = 1'b1; ic[2] = 8'hFF; id[2] = 16'h0099;
    tick();
    fl[2] = 1'b0; iv[2] = 1'b0;
    check("flush_valid", 2, ov[2], 1'b0);
    check("flush_occ", 2, get_occ(2), 4'd0);
    check("flush_ctrl", 2, oc[2], 8'h00);
    ordy[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("flushed_gone", 2, ov[2], 1'b0);
    end
    check("flush_keeps_data", 2, od[2], 16'h0031);

    // Reset glitch between edges is ignored; a sampled reset empties the block
    ordy[1] = 1'b0; ic[1] = 8'h5A;
    for (int k = 0; k < 2; k++) begin
      id[1] = 16'(16'h0051 + k); iv[1] = 1'b1;
      tick();
    end
    iv[1] = 1'b0;
    #1 rs[1] = 1'b1;
    #2 rs[1] = 1'b0;
    tick();
    check("glitch_occ", 1, get_occ(1), 4'd2);
    check("glitch_valid", 1, ov[1], 1'b1);
    check("glitch_data", 1, od[1], 16'h0051);
    rs[1] = 1'b1;
    tick();
    rs[1] = 1'b0;
    check("reset_valid", 1, ov[1], 1'b0);
    check("reset_data", 1, od[1], 16'h0);
    check("reset_occ", 1, get_occ(1), 4'd0);
    check("reset_ready", 1, ir[1], 1'b1);
    check("reset_ctrl", 1, oc[1], 8'h00);

    // Random traffic on all configurations
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        id[i]   = 16'($urandom);
        ic[i]   = 8'($urandom);
        ordy[i] = ($urandom_range(0, 1) != 0);
        fl[i]   = ($urandom_range(0, 63) == 0);
        rs[i]   = ($urandom_range(0, 255) == 0);
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; rs[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (10) tick();
    for (int i = 0; i < N; i++) begin
      check("final_occ", i, get_occ(i), 4'd0);
      check("final_valid", i, ov[i], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic replacement for the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle through DEPTH chained stages with valid/ready handshake, stall, flush and bubble insertion.
- Clearing the control bundle on bubbles guarantees that squashed slots never assert RegWrite/MemWrite downstream.
- Sits between any two pipeline stages of the core.

Parameters:
- DATA_W, 96, width of data bundle (e.g. MemData+ALUOut+PCAdd4).
- CTRL_W, 8, width of control bundle (RegWrite, MemtoReg, WriteReg, ...).
- DEPTH, 1, number of chained register stages (1..8).
- SKID, 1, selects the per-stage slot type: 1 = 2-entry skid slot with registered in_ready; 0 = single register with ready passed through combinationally.
- CTRL_CLEAR, 1, selects out_ctrl on bubbles: 1 = out_ctrl forced to 0 whenever out_valid=0; 0 = out_ctrl holds its last value.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, upstream has a valid bundle.
- in_ready, output, 1, block can accept this cycle.
- in_data, input, DATA_W, data bundle in.
- in_ctrl, input, CTRL_W, control bundle in.
- out_valid, output, 1, bundle at output is valid.
- out_ready, input, 1, downstream accepts; tie to 1 for no backpressure.
- out_data, output, DATA_W, data bundle out.
- out_ctrl, output, CTRL_W, control bundle out (masked per CTRL_CLEAR).
- flush, input, 1, squash all in-flight entries.
- occupancy, output, $clog2(2*DEPTH+1), number of valid entries held.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: all valid bits 0, all data/ctrl registers 0, out_valid=0, out_data=0, out_ctrl=0, occupancy=0. in_ready=1 in the cycle after reset.
- Transfers: input transfer happens when in_valid && in_ready at a rising edge; output transfer happens when out_valid && out_ready.
- Latency and throughput: DEPTH cycles from input transfer to out_valid with out_ready held at 1. Sustained throughput is 1 bundle/cycle.
- SKID=1 slot:
  - States EMPTY, MAIN, FULL.
  - in_ready = !skid_valid, a pure register output.
  - EMPTY + push -> MAIN.
  - MAIN + push, no pop -> FULL (bundle goes to skid).
  - MAIN + push + pop -> MAIN (main loads new bundle).
  - MAIN + pop -> EMPTY.
  - FULL + pop -> MAIN (skid moves to main). No push is possible in FULL.
- SKID=0 slot:
  - in_ready = out_ready || !valid (combinational path).
  - Holds a single entry; occupancy per stage is 0..1.
- Chaining: stage k's output handshake is stage k+1's input handshake. The stall from out_ready=0 propagates upstream one stage per cycle (SKID=1) or in the same cycle (SKID=0).
- Stall: with out_ready=0, out_data/out_ctrl remain bit-stable while out_valid=1. No bundle is dropped or duplicated.
- flush:
  - At the rising edge with flush=1, every valid bit clears. A bundle accepted in the same cycle is discarded.
  - The next cycle shows out_valid=0 and occupancy=0.
  - Data registers keep their contents; only valid bits clear.
  - flush has priority over push and pop.
  - reset has priority over flush.
- Bubble: when out_valid=0 and CTRL_CLEAR=1, out_ctrl=0 combinationally. out_data still shows the register contents.
- occupancy: registered sum of valid bits, updated every edge. Push and pop in the same cycle leave it unchanged.
- Reset mid-stream: all entries are lost. No output transfer is reported in the reset cycle.
- Integrity: the block never reorders entries. Data width is passed through untouched; no arithmetic is performed on the data.

Decomposition:
- Shared package pipe_pkg holds:
  - localparam function occ_w(depth) = $clog2(2*depth+1).
  - typedef enum slot_state_e {EMPTY, MAIN, FULL}.
  - Default widths for each named stage (IFID_DATA_W, MEMWB_CTRL_W, ...).
- Sub-module pipe_skid_slot implements one stage, with parameters WIDTH=DATA_W+CTRL_W and SKID.
- Top level instantiates DEPTH slots via a generate loop, chains the handshakes, ORs flush into every slot, and builds occupancy and the CTRL_CLEAR mask.

Test Plan:
- DEPTH=1, SKID=1, out_ready=1, push 0x11..0x15 on consecutive cycles -> out_data 0x11..0x15 on cycles 1..5. occupancy stays at 1; in_ready stays at 1.
- DEPTH=2, SKID=1, push 6 bundles with out_ready=0 -> in_ready drops after 4 accepts and occupancy=4. After out_ready=1, the 4 bundles exit in order with no loss or duplication.
- DEPTH=3 with 3 entries in flight, flush=1 together with in_valid=1 and in_ctrl=0xFF -> next cycle out_valid=0, occupancy=0, out_ctrl=0x00. The flushed-cycle bundle never appears at the output.
- CTRL_CLEAR=1, in_ctrl=0xA5 then idle -> out_ctrl=0xA5 while valid, then 0x00. With CTRL_CLEAR=0, out_ctrl holds 0xA5.
- Reset asserted for 1 cycle with 2 entries held -> next edge shows out_valid=0, out_data=0, occupancy=0, in_ready=1. An asynchronous reset pulse between edges has no effect.
- SKID=0, DEPTH=2, random in_valid/out_ready over 1000 cycles -> scoreboard shows in-order, lossless transfer. in_ready matches out_ready || !valid in every cycle.
